// File: rtl/jolt_pkg.sv
// Shared types for the joltage pipeline: BCD digits, the packed 2-digit joltage
// that the finder produces, and the accumulator FSM states.
package jolt_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } jolt_state_e;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } joltage_t;

  function automatic logic is_bcd_joltage(joltage_t j);
    return (j.tens <= BCD_MAX) && (j.units <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder with decimal correction: digit = (a+b+cin) mod 10.
// Inputs are assumed to be legal BCD digits, so the raw sum never exceeds 19.
module bcd_digit_add
  import jolt_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] raw;

  always_comb begin
    raw   = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    cout  = (raw > 5'(BCD_MAX));
    digit = cout ? 4'(raw - 5'd10) : raw[3:0];
  end

endmodule

// File: rtl/jolt_sum_accumulator.sv
// Accumulates per-bank 2-digit BCD joltages into a multi-digit BCD total,
// one digit per clock, and holds the final total until the sink takes it.
module jolt_sum_accumulator
  import jolt_pkg::*;
#(
  parameter int SUM_DIGITS  = 6,
  parameter int COUNT_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_bcd,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*SUM_DIGITS-1:0]   sum_bcd,
  output logic [COUNT_WIDTH-1:0]    bank_count,
  output logic                      overflow,
  output logic                      bad_digit
);

  localparam int IDX_W = $clog2(SUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SUM_DIGITS - 1);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ADD  = ADD;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]             state;
  logic [IDX_W-1:0]       idx;
  logic                   carry;
  joltage_t               lat_jolt;
  logic                   lat_last;

  joltage_t               in_jolt;
  logic                   in_ok;
  logic                   take;
  logic [COUNT_WIDTH:0]   count_inc;

  logic [3:0]             sum_digit;
  logic [3:0]             addend;
  logic [3:0]             add_digit;
  logic                   add_cout;
  logic [4*SUM_DIGITS-1:0] sum_upd;

  assign in_jolt   = in_bcd;
  assign in_ok     = is_bcd_joltage(in_jolt);
  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE) && !rst;
  assign take      = in_valid && in_ready;
  assign count_inc = {1'b0, bank_count} + (COUNT_WIDTH + 1)'(1);

  // Only digits 0 and 1 receive the joltage; higher digits just ripple the carry.
  always_comb begin
    sum_digit = 4'd0;
    for (int i = 0; i < SUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) sum_digit = sum_bcd[4*i +: 4];
    end
    if (idx == IDX_W'(0))      addend = lat_jolt.units;
    else if (idx == IDX_W'(1)) addend = lat_jolt.tens;
    else                       addend = 4'd0;
  end

  bcd_digit_add u_digit_add (
    .a     (sum_digit),
    .b     (addend),
    .cin   (carry),
    .digit (add_digit),
    .cout  (add_cout)
  );

  always_comb begin
    sum_upd = sum_bcd;
    for (int i = 0; i < SUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) sum_upd[4*i +: 4] = add_digit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      carry      <= 1'b0;
      lat_jolt   <= '0;
      lat_last   <= 1'b0;
      sum_bcd    <= '0;
      bank_count <= '0;
      overflow   <= 1'b0;
      bad_digit  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take) begin
            if (!in_ok) begin
              bad_digit <= 1'b1;
              if (in_last) state <= S_DONE;
            end else begin
              lat_jolt   <= in_jolt;
              lat_last   <= in_last;
              bank_count <= count_inc[COUNT_WIDTH-1:0];
              if (count_inc[COUNT_WIDTH]) overflow <= 1'b1;
              carry      <= 1'b0;
              idx        <= '0;
              state      <= S_ADD;
            end
          end
        end
        // Always walks every digit so the add latency is fixed.
        S_ADD: begin
          sum_bcd <= sum_upd;
          carry   <= add_cout;
          if (idx == LAST_IDX) begin
            idx <= '0;
            if (add_cout) overflow <= 1'b1;
            state <= lat_last ? S_DONE : S_IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            sum_bcd    <= '0;
            bank_count <= '0;
            overflow   <= 1'b0;
            bad_digit  <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/jolt_sum_accumulator.md
Name: jolt_sum_accumulator

Overview:
- Downstream consumer of the per-bank max-joltage finder.
- Accepts one 2-digit packed-BCD joltage per bank over a valid/ready handshake and adds it into a multi-digit BCD running total. The add is digit-serial, one BCD digit per clock.
- On the bank flagged last, presents the final BCD total and bank count until the sink takes them.

Parameters:
- SUM_DIGITS, 6, number of BCD digits in the total (sum width 4*SUM_DIGITS); minimum 2.
- COUNT_WIDTH, 12, width of the binary accepted-bank counter.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bcd/in_last valid.
- in_ready  output  1  block can accept an item.
- in_bcd  input  8  joltage, packed BCD: [7:4] tens, [3:0] units.
- in_last  input  1  this item is the final bank of the set.
- out_valid  output  1  final result held on outputs.
- out_ready  input  1  sink takes result.
- sum_bcd  output  4*SUM_DIGITS  BCD total, digit 0 at [3:0].
- bank_count  output  COUNT_WIDTH  number of valid items added.
- overflow  output  1  sticky: carry out of the top digit, or bank_count wrapped.
- bad_digit  output  1  sticky: an item with a nibble >9 was received.

Behaviour:
- Reset: state IDLE; sum_bcd=0, bank_count=0, overflow=0, bad_digit=0, out_valid=0, in_ready=0 during the reset cycle. in_ready=1 from the first cycle after reset. Reset in any state aborts the operation and discards a partial sum.
- States: IDLE, ADD, DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- IDLE, no transfer (in_valid=0): stay.
- IDLE, transfer with a nibble >9:
  - Set bad_digit.
  - Item not added; bank_count unchanged.
  - If in_last, go to DONE; else stay IDLE.
- IDLE, transfer with valid BCD:
  - Latch in_bcd and in_last.
  - Increment bank_count; wrap to 0 sets overflow.
  - Clear the carry; digit index=0; go to ADD.
- ADD, each cycle processes digit idx:
  - Addend nibble: units for idx0, tens for idx1, 0 above that.
  - t = sum_digit + addend + carry. If t>9: digit = t-10, carry=1; else digit = t, carry=0.
  - Write the digit back into sum_bcd; idx++.
  - After idx = SUM_DIGITS-1: if carry=1, set overflow (the sum keeps its low SUM_DIGITS digits, i.e. wraps modulo 10^SUM_DIGITS). Go to DONE if the latched last=1, else IDLE.
- Latency and throughput:
  - ADD lasts exactly SUM_DIGITS cycles.
  - in_ready reasserts, or out_valid asserts, SUM_DIGITS edges after the accepting edge.
  - Throughput: one item per SUM_DIGITS+1 cycles.
- sum_bcd is only guaranteed coherent in IDLE or DONE; mid-ADD it is partially updated.
- DONE:
  - sum_bcd, bank_count, overflow and bad_digit are held stable; in_valid is ignored.
  - On out_ready=1: next cycle clears sum, count and both flags, and returns to IDLE.
  - out_ready while not in DONE is ignored.
- Early add termination is not permitted; fixed cycle count.

Decomposition:
- Shared package (jolt_pkg):
  - BCD digit typedef (4 bits).
  - Constant BCD_MAX=9.
  - FSM state enum: IDLE, ADD, DONE.
  - Packed 2-digit joltage typedef, also to be used by the finder's output port.
- One sub-module, bcd_digit_add: combinational, (a, b, cin) -> (digit, cout); single-digit BCD add with the >9 correction. It is reused by the future checksum/report stages.

Test Plan:
- Basic sum (SUM_DIGITS=6): send 0x98, 0x89, 0x78, 0x92 (last on 0x92) -> out_valid with sum_bcd=0x000357, bank_count=4, overflow=0, bad_digit=0; each accept followed by exactly 6 cycles of in_ready=0.
- Single item: 0x12 with in_last, out_ready=1 -> out_valid exactly 6 edges after accept, sum=0x000012, count=1; next cycle sum=0, in_ready=1.
- Overflow (SUM_DIGITS=3): eleven items of 0x99, last on the 11th -> sum_bcd=0x089, overflow=1, bank_count=11.
- Bad digit: items 0x45, 0xA3, 0x27 (last) -> bad_digit=1, sum=0x000072, count=2; 0xA3 consumed in one cycle with no ADD.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 -> outputs stable, in_ready=0, nothing consumed; release -> clear, then the pending input accepted.
- Reset mid-ADD: assert rst on the 3rd ADD cycle of adding 0x55 onto 0x000050 -> next cycle sum=0, count=0, flags=0, state IDLE; no partial value ever reaches out_valid.
